aes_core_scheduler: RTL and testbench
=====================================

Name: aes_core_scheduler

Overview:
- Shares one AES_Top encryption core between two requesters (channel 0, channel 1) with round-robin arbitration.
- Sequences the core: loads the key only when the granted channel's key differs from the key currently loaded, then loads the data block and waits for the ciphertext.
- Returns the ciphertext to the owning channel, and flags a core that never answers with a timeout error.
- Sits between the per-channel bus wrappers and the AES_Top instance.

Parameters:
- TIMEOUT_CYCLES, 1024, max cycles in CT_WAIT before the timeout fires; legal range 16..65535.
- TMR_W, 16, timeout counter width; must satisfy 2^TMR_W > TIMEOUT_CYCLES.

Ports:
- iClk  in  1  clock; all logic on the rising edge.
- iReset  in  1  synchronous, active-high reset.
- iValid  in  2  per-channel request; iKeyN/iPtN held stable while high.
- iKey0  in  128  channel 0 key.
- iKey1  in  128  channel 1 key.
- iPt0  in  128  channel 0 plaintext.
- iPt1  in  128  channel 1 plaintext.
- oAccept  out  2  one-cycle pulse: request consumed.
- oCt  out  128  ciphertext, valid while any oCtValid bit is high.
- oCtValid  out  2  one-cycle pulse on the owning channel's bit.
- oBusy  out  1  high in every state except IDLE.
- oErr  out  1  sticky timeout flag; cleared only by reset.
- oCoreData  out  128  to AES_Top in_data.
- oCoreLoadKey  out  1  to AES_Top Load_Key, one-cycle pulse.
- oCoreLoadData  out  1  to AES_Top Load_Data, one-cycle pulse.
- iCoreReady  in  1  from AES_Top Ready_new_input.
- iCoreCtValid  in  1  from AES_Top CTValid.
- iCoreCt  in  128  from AES_Top CipherText.

Behaviour:
- All outputs registered. Reset values:
  - oAccept=0, oCtValid=0, oCoreLoadKey=0, oCoreLoadData=0.
  - oCt=0, oCoreData=0, oBusy=0, oErr=0.
  - State=IDLE, last=1, keyCached=0, timer=0.
- State machine: IDLE, KEY_LOAD, KEY_WAIT, DATA_LOAD, CT_WAIT.
- IDLE, arbitration:
  - One valid bit set: grant that channel.
  - Both set: grant the channel that is not `last`. After reset, channel 0 wins the first tie.
  - On grant: register g and set last=g.
  - If keyCached=1 and iKeyg equals the stored key register, go to DATA_LOAD; otherwise go to KEY_LOAD.
- KEY_LOAD:
  - While iCoreReady=0, wait.
  - When iCoreReady=1, drive oCoreData=iKeyg and oCoreLoadKey=1 for one cycle.
  - Store the key, set keyCached=1, go to KEY_WAIT.
- KEY_WAIT:
  - Ignore iCoreReady in the first cycle after entry, because the core may drop ready late.
  - After that, go to DATA_LOAD when iCoreReady=1.
- DATA_LOAD:
  - When iCoreReady=1, in the same cycle drive oCoreData=block, oCoreLoadData=1 and oAccept[g]=1.
  - Clear timer, go to CT_WAIT.
- CT_WAIT:
  - Timer increments every cycle.
  - On iCoreCtValid: capture iCoreCt into oCt, pulse oCtValid[g] on the next cycle, return to IDLE.
  - Best case: a new grant is taken in the IDLE cycle after the oCtValid pulse.
  - Timeout (timer==TIMEOUT_CYCLES-1 without iCoreCtValid): set oErr=1, clear keyCached, go to IDLE, no oCtValid. The request was already accepted and is not retried.
- iCoreCtValid outside CT_WAIT is ignored.
- iValid dropping before oAccept is a protocol violation. Behaviour is undefined, apart from the FSM reaching IDLE again.
- iReset mid-operation: all state returns to reset values on the next edge. keyCached=0 forces the next request to reload its key.
- Core signals are level-sampled; there is no combinational path from any input to any output.

Optional Feature:
- Macro AES_SCHED_CBC_EN.
- Defined:
  - Per-channel 128-bit chain register cv0/cv1, reset to 0.
  - block = iPtg XOR cvg.
  - On oCtValid[g], cvg <= ciphertext.
  - A key load for channel g also clears cvg (new key starts a new chain with IV=0).
- Undefined: block = iPtg (ECB); no chain registers are synthesised.

Decomposition:
- Package aes_sched_pkg holds:
  - state encoding (3-bit localparams for the five states);
  - channel count NUM_CH=2;
  - AES block width BLK_W=128.
- One natural sub-module: aes_rr_arbiter, a 2-way round-robin arbiter with registered last-grant and a one-hot grant output.

Test Plan:
- Single request, ch0: key K, pt P, core model latency 11 cycles. Expect one oCoreLoadKey, then one oCoreLoadData with oCoreData=P, oAccept=01, and oCtValid=01 with oCt=model(K,P).
- Back-to-back ch0 requests with the same key. Expect exactly one oCoreLoadKey over 2 blocks; the second accept starts no earlier than 1 cycle after the first oCtValid.
- Both channels valid continuously, different keys. Expect grants alternating 0,1,0,1 and a key reload before every block (4 oCoreLoadKey for 4 blocks).
- Core model never asserts CTValid. Expect oErr=1 exactly TIMEOUT_CYCLES cycles after oCoreLoadData, no oCtValid, oBusy=0 the next cycle. A following request must reload its key.
- Assert iReset during CT_WAIT, then send a stray iCoreCtValid. Expect all outputs at reset values and no oCtValid pulse.
- With AES_SCHED_CBC_EN defined: ch1 sends P1 then P2 under the same key. Expect the second oCoreData=P2 XOR C1 and the first oCoreData=P1.

Source files
------------

// File: rtl/aes_sched_pkg.sv
// aes_sched_pkg: shared constants and FSM encoding for the
// AES core scheduler.
package aes_sched_pkg;

   localparam int NUM_CH = 2;
   localparam int BLK_W  = 128;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_KEY_LOAD  = 3'd1;
   localparam logic [2:0] ST_KEY_WAIT  = 3'd2;
   localparam logic [2:0] ST_DATA_LOAD = 3'd3;
   localparam logic [2:0] ST_CT_WAIT   = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE      = ST_IDLE,
      S_KEY_LOAD  = ST_KEY_LOAD,
      S_KEY_WAIT  = ST_KEY_WAIT,
      S_DATA_LOAD = ST_DATA_LOAD,
      S_CT_WAIT   = ST_CT_WAIT
   } state_e;

endpackage

// File: rtl/aes_rr_arbiter.sv
// aes_rr_arbiter: 2-way round-robin arbiter, registered
// last-grant, one-hot grant output.
module aes_rr_arbiter
   import aes_sched_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NUM_CH-1:0] req_i,
   input  logic              en_i,
   output logic [NUM_CH-1:0] gnt_o
);

   logic last_q, last_d;

   // Grant decode: on a tie the channel that did not win last goes.
   always_comb begin
      gnt_o = '0;
      unique case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
         default: gnt_o = '0;
      endcase
      last_d = last_q;
      if (en_i && (|req_i)) begin
         last_d = gnt_o[1];
      end
   end

   // Last-grant register; reset to 1 so channel 0 wins the first tie.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/aes_core_scheduler.sv
// aes_core_scheduler: shares one AES_Top core between two channels.
// Define AES_SCHED_CBC_EN to enable per-channel CBC chaining.
module aes_core_scheduler
   import aes_sched_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int TMR_W          = 16
) (
   input  logic              iClk,
   input  logic              iReset,
   input  logic [NUM_CH-1:0] iValid,
   input  logic [BLK_W-1:0]  iKey0,
   input  logic [BLK_W-1:0]  iKey1,
   input  logic [BLK_W-1:0]  iPt0,
   input  logic [BLK_W-1:0]  iPt1,
   output logic [NUM_CH-1:0] oAccept,
   output logic [BLK_W-1:0]  oCt,
   output logic [NUM_CH-1:0] oCtValid,
   output logic              oBusy,
   output logic              oErr,
   output logic [BLK_W-1:0]  oCoreData,
   output logic              oCoreLoadKey,
   output logic              oCoreLoadData,
   input  logic              iCoreReady,
   input  logic              iCoreCtValid,
   input  logic [BLK_W-1:0]  iCoreCt
);

   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   state_e            state_q, state_d;
   logic              g_q, g_d;
   logic [BLK_W-1:0]  key_q, key_d;
   logic              cached_q, cached_d;
   logic              kwfirst_q, kwfirst_d;
   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic [NUM_CH-1:0] acc_q, acc_d;
   logic [NUM_CH-1:0] ctv_q, ctv_d;
   logic [BLK_W-1:0]  ct_q, ct_d;
   logic [BLK_W-1:0]  cdata_q, cdata_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;
   logic              lk_q, lk_d;
   logic              ld_q, ld_d;

   logic [NUM_CH-1:0] gnt;
   logic              gsel;
   logic [BLK_W-1:0]  key_sel;
   logic [BLK_W-1:0]  pt_sel;
   logic [BLK_W-1:0]  blk;

   aes_rr_arbiter u_arb (
      .clk_i (iClk),
      .rst_i (iReset),
      .req_i (iValid),
      .en_i  (state_q == S_IDLE),
      .gnt_o (gnt)
   );

   // In IDLE the key compare uses the fresh grant, later the stored one.
   assign gsel    = (state_q == S_IDLE) ? gnt[1] : g_q;
   assign key_sel = gsel ? iKey1 : iKey0;
   assign pt_sel  = g_q ? iPt1 : iPt0;

`ifdef AES_SCHED_CBC_EN
   logic [NUM_CH-1:0][BLK_W-1:0] cv_q, cv_d;
   assign blk = pt_sel ^ cv_q[g_q];
`else
   assign blk = pt_sel;
`endif

   // Next-state and registered-output decode.
   always_comb begin
      state_d   = state_q;
      g_d       = g_q;
      key_d     = key_q;
      cached_d  = cached_q;
      kwfirst_d = 1'b0;
      tmr_d     = tmr_q;
      acc_d     = '0;
      ctv_d     = '0;
      ct_d      = ct_q;
      cdata_d   = cdata_q;
      err_d     = err_q;
      lk_d      = 1'b0;
      ld_d      = 1'b0;
`ifdef AES_SCHED_CBC_EN
      cv_d      = cv_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (|gnt) begin
               g_d = gnt[1];
               if (cached_q && (key_sel == key_q)) begin
                  state_d = S_DATA_LOAD;
               end else begin
                  state_d = S_KEY_LOAD;
               end
            end
         end
         S_KEY_LOAD: begin
            if (iCoreReady) begin
               cdata_d   = key_sel;
               lk_d      = 1'b1;
               key_d     = key_sel;
               cached_d  = 1'b1;
               kwfirst_d = 1'b1;
               state_d   = S_KEY_WAIT;
`ifdef AES_SCHED_CBC_EN
               cv_d[g_q] = '0;
`endif
            end
         end
         S_KEY_WAIT: begin
            // The core may still show ready right after Load_Key.
            if (!kwfirst_q && iCoreReady) begin
               state_d = S_DATA_LOAD;
            end
         end
         S_DATA_LOAD: begin
            if (iCoreReady) begin
               cdata_d    = blk;
               ld_d       = 1'b1;
               acc_d[g_q] = 1'b1;
               tmr_d      = '0;
               state_d    = S_CT_WAIT;
            end
         end
         S_CT_WAIT: begin
            tmr_d = tmr_q + 1'b1;
            if (iCoreCtValid) begin
               ct_d       = iCoreCt;
               ctv_d[g_q] = 1'b1;
               state_d    = S_IDLE;
`ifdef AES_SCHED_CBC_EN
               cv_d[g_q]  = iCoreCt;
`endif
            end else if (tmr_q == TMR_LAST) begin
               err_d    = 1'b1;
               cached_d = 1'b0;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge iClk) begin
      if (iReset) begin
         state_q   <= S_IDLE;
         g_q       <= 1'b0;
         key_q     <= '0;
         cached_q  <= 1'b0;
         kwfirst_q <= 1'b0;
         tmr_q     <= '0;
         acc_q     <= '0;
         ctv_q     <= '0;
         ct_q      <= '0;
         cdata_q   <= '0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
         lk_q      <= 1'b0;
         ld_q      <= 1'b0;
`ifdef AES_SCHED_CBC_EN
         cv_q      <= '0;
`endif
      end else begin
         state_q   <= state_d;
         g_q       <= g_d;
         key_q     <= key_d;
         cached_q  <= cached_d;
         kwfirst_q <= kwfirst_d;
         tmr_q     <= tmr_d;
         acc_q     <= acc_d;
         ctv_q     <= ctv_d;
         ct_q      <= ct_d;
         cdata_q   <= cdata_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
         lk_q      <= lk_d;
         ld_q      <= ld_d;
`ifdef AES_SCHED_CBC_EN
         cv_q      <= cv_d;
`endif
      end
   end

   assign oAccept       = acc_q;
   assign oCtValid      = ctv_q;
   assign oCt           = ct_q;
   assign oBusy         = busy_q;
   assign oErr          = err_q;
   assign oCoreData     = cdata_q;
   assign oCoreLoadKey  = lk_q;
   assign oCoreLoadData = ld_q;

endmodule

// File: tb/tb_aes_core_scheduler.sv
// tb_aes_core_scheduler: directed bench for aes_core_scheduler
// with a behavioural AES_Top stand-in (ct = key ^ block).
module tb_aes_core_scheduler;

   localparam logic [127:0] K0 = {16{8'hA0}};
   localparam logic [127:0] K1 = {16{8'h0B}};
   localparam logic [127:0] P1 = {16{8'h01}};
   localparam logic [127:0] P2 = {16{8'h02}};
   localparam logic [127:0] P3 = {16{8'h04}};
   localparam logic [127:0] P4 = {16{8'h08}};

   logic         iClk = 1'b0;
   logic         iReset = 1'b1;
   logic [1:0]   iValid = '0;
   logic [127:0] iKey0 = '0, iKey1 = '0, iPt0 = '0, iPt1 = '0;
   logic [1:0]   oAccept, oCtValid;
   logic [127:0] oCt, oCoreData;
   logic         oBusy, oErr, oCoreLoadKey, oCoreLoadData;
   logic         mrdy = 1'b1;
   logic         mct_v = 1'b0;
   logic [127:0] mct = '0;

   aes_core_scheduler dut (
      .iClk          (iClk),
      .iReset        (iReset),
      .iValid        (iValid),
      .iKey0         (iKey0),
      .iKey1         (iKey1),
      .iPt0          (iPt0),
      .iPt1          (iPt1),
      .oAccept       (oAccept),
      .oCt           (oCt),
      .oCtValid      (oCtValid),
      .oBusy         (oBusy),
      .oErr          (oErr),
      .oCoreData     (oCoreData),
      .oCoreLoadKey  (oCoreLoadKey),
      .oCoreLoadData (oCoreLoadData),
      .iCoreReady    (mrdy),
      .iCoreCtValid  (mct_v),
      .iCoreCt       (mct)
   );

   always #5 iClk = ~iClk;

   // Core stand-in: 2-cycle key expansion, 11-cycle block latency.
   logic [127:0] mkey = '0, mdat = '0;
   int           kcnt = 0, lcnt = 0;
   bit           mbusy = 1'b0, hang = 1'b0;
   always @(posedge iClk) begin
      mct_v <= 1'b0;
      if (oCoreLoadKey) begin
         mkey <= oCoreData;
         mrdy <= 1'b0;
         kcnt <= 2;
      end else if (oCoreLoadData) begin
         mdat  <= oCoreData;
         mrdy  <= 1'b0;
         lcnt  <= 11;
         mbusy <= 1'b1;
      end else if (kcnt != 0) begin
         kcnt <= kcnt - 1;
         if (kcnt == 1) mrdy <= 1'b1;
      end else if (mbusy) begin
         lcnt <= lcnt - 1;
         if (lcnt == 1) begin
            mbusy <= 1'b0;
            mrdy  <= 1'b1;
            if (!hang) begin
               mct_v <= 1'b1;
               mct   <= mkey ^ mdat;
            end
         end
      end
   end

   int checks = 0, failures = 0, cyc = 0;
   int nkey, nld, nct, nacc, ld_cyc, err_cyc;
   bit err_seen;
   logic [127:0] ld_log [8];
   logic [127:0] ct_log [8];
   logic [1:0]   ctch_log [8];
   logic [1:0]   acc_log [8];
   int           acc_cyc [8];
   int           ct_cyc [8];
   logic [127:0] ptq0 [4];
   logic [127:0] ptq1 [4];

   task automatic check(input string tag, input logic [127:0] got,
                        input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic clr_logs();
      nkey = 0; nld = 0; nct = 0; nacc = 0;
      ld_cyc = 0; err_cyc = 0; err_seen = 1'b0;
   endtask

   task automatic sample();
      if (oCoreLoadKey) nkey++;
      if (oCoreLoadData) begin
         if (nld < 8) ld_log[nld] = oCoreData;
         ld_cyc = cyc;
         nld++;
      end
      if (oAccept != 2'b00) begin
         if (nacc < 8) begin
            acc_log[nacc] = oAccept;
            acc_cyc[nacc] = cyc;
         end
         nacc++;
      end
      if (oCtValid != 2'b00) begin
         if (nct < 8) begin
            ct_log[nct]   = oCt;
            ctch_log[nct] = oCtValid;
            ct_cyc[nct]   = cyc;
         end
         nct++;
      end
      if (oErr && !err_seen) begin
         err_seen = 1'b1;
         err_cyc  = cyc;
      end
   endtask

   task automatic step();
      @(posedge iClk);
      #1;
      cyc++;
      sample();
   endtask

   task automatic do_reset();
      iReset = 1'b1;
      iValid = '0;
      step();
      step();
      iReset = 1'b0;
      clr_logs();
   endtask

   task automatic check_reset_outs();
      check("rst_accept", 128'(oAccept), 128'd0);
      check("rst_ctvalid", 128'(oCtValid), 128'd0);
      check("rst_ct", oCt, 128'd0);
      check("rst_coredata", oCoreData, 128'd0);
      check("rst_busy_err", 128'({oBusy, oErr}), 128'd0);
      check("rst_loads", 128'({oCoreLoadKey, oCoreLoadData}), 128'd0);
   endtask

   // Hold requests per channel, advancing the block on each accept.
   task automatic run(input int n0, input int n1, input bit want_err);
      int  i0, i1, budget;
      bit  done;
      i0 = 0; i1 = 0; budget = 3000; done = 1'b0;
      clr_logs();
      iPt0 = ptq0[0];
      iPt1 = ptq1[0];
      iValid = {n1 > 0, n0 > 0};
      while (!done && budget > 0) begin
         step();
         budget--;
         if (oAccept[0]) begin
            i0++;
            if (i0 < n0) iPt0 = ptq0[i0];
            else iValid[0] = 1'b0;
         end
         if (oAccept[1]) begin
            i1++;
            if (i1 < n1) iPt1 = ptq1[i1];
            else iValid[1] = 1'b0;
         end
         done = want_err ? err_seen : (nct == n0 + n1);
      end
      iValid = '0;
      check("run_done", 128'(done), 128'd1);
   endtask

   initial begin
      clr_logs();
      iKey0 = K0;
      iKey1 = K1;
      do_reset();
      check_reset_outs();

      // Single ch0 block.
      ptq0[0] = P1;
      run(1, 0, 1'b0);
      check("t1_loadkey", 128'(nkey), 128'd1);
      check("t1_data", ld_log[0], P1);
      check("t1_accept", 128'(acc_log[0]), 128'd1);
      check("t1_ctch", 128'(ctch_log[0]), 128'd1);
      check("t1_ct", ct_log[0], {16{8'hA1}});

      // Back-to-back ch0, same key.
      do_reset();
      ptq0[0] = P2;
      ptq0[1] = P3;
      run(2, 0, 1'b0);
      check("t2_loadkey", 128'(nkey), 128'd1);
      check("t2_gap", 128'(acc_cyc[1] - ct_cyc[0] >= 1), 128'd1);
      check("t2_ct0", ct_log[0], {16{8'hA2}});
      check("t2_ct1", ct_log[1], {16{8'hA4}});

      // Both channels continuously, different keys.
      do_reset();
      ptq0[0] = P1; ptq0[1] = P2;
      ptq1[0] = P3; ptq1[1] = P4;
      run(2, 2, 1'b0);
      check("t3_order", 128'({acc_log[0], acc_log[1],
                              acc_log[2], acc_log[3]}),
            128'(8'b01_10_01_10));
      check("t3_loadkey", 128'(nkey), 128'd4);
      check("t3_ct0", ct_log[0], {16{8'hA1}});
      check("t3_ct1", ct_log[1], {16{8'h0F}});
      check("t3_ct2", ct_log[2], {16{8'hA2}});
      check("t3_ct3", ct_log[3], {16{8'h03}});

      // Core never answers.
      do_reset();
      hang = 1'b1;
      ptq0[0] = P1;
      run(1, 0, 1'b1);
      check("t4_err_delay", 128'(err_cyc - ld_cyc), 128'd1024);
      check("t4_no_ct", 128'(nct), 128'd0);
      step();
      check("t4_busy_after", 128'(oBusy), 128'd0);
      check("t4_err_sticky", 128'(oErr), 128'd1);
      hang = 1'b0;
      run(1, 0, 1'b0);
      check("t4_reload", 128'(nkey), 128'd1);
      check("t4_ct", ct_log[0], {16{8'hA1}});

      // Reset in CT_WAIT, then a stray CTValid from the core.
      do_reset();
      iPt0 = P1;
      iValid = 2'b01;
      for (int i = 0; i < 50 && nacc == 0; i++) step();
      iValid = '0;
      step();
      step();
      check("t5_busy_mid", 128'(oBusy), 128'd1);
      iReset = 1'b1;
      step();
      check_reset_outs();
      iReset = 1'b0;
      clr_logs();
      repeat (20) step();
      check("t5_no_ct", 128'(nct), 128'd0);
      check("t5_idle", 128'({oBusy, oErr}), 128'd0);
      ptq0[0] = P1;
      run(1, 0, 1'b0);
      check("t5_reload", 128'(nkey), 128'd1);

      // ch1 two blocks under one key.
      do_reset();
      ptq1[0] = P1;
      ptq1[1] = P2;
      run(0, 2, 1'b0);
      check("t6_data0", ld_log[0], P1);
`ifdef AES_SCHED_CBC_EN
      check("t6_data1", ld_log[1], {16{8'h08}});
      check("t6_ct1", ct_log[1], {16{8'h03}});
`else
      check("t6_data1", ld_log[1], P2);
      check("t6_ct1", ct_log[1], {16{8'h09}});
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
